// File: rtl/cdc_pkg.sv
// Shared types and limits for the req/ack CDC handshake transmitter.
// Holds the FSM state enum, sync-depth limits and the default word width.
package cdc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } hs_state_e;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int DATA_W_DEF      = 8;

endpackage

// File: rtl/hs_ack_sync.sv
// Flop-chain synchronizer for the asynchronous acknowledge level.
// Ports: clk_i, rst_i (sync, active-high, clears chain), d_i async in, q_o synced out.
module hs_ack_sync
   import cdc_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_MIN
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack CDC handshake: holds one word on data_o
// while req_o is high, waits for synced ack, then completes return-to-zero.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data local side;
// req_o/data_o/ack_i destination side; busy_o, done_o (1-cycle), err_o (sticky).
// Optional macro CDC_HS_TIMEOUT_EN: abort REQ after TIMEOUT_CYC cycles without ack.
module cdc_hs_tx
   import cdc_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              req_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
       TIMEOUT_CYC < 4) begin : g_param_chk
      $error("cdc_hs_tx: illegal parameter value");
   end

   logic ack_s;

   hs_ack_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (ack_i),
      .q_o   (ack_s)
   );

   hs_state_e         state_q, state_d;
   logic              req_q, req_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;

`ifdef CDC_HS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   // Marks a word that left REQ by timeout so DRAIN exit gives no done pulse.
   logic             abort_q, abort_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
         done_q  <= done_d;
`ifdef CDC_HS_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         abort_q <= abort_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
      abort_d = abort_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               req_d   = 1'b1;
               state_d = REQ;
`ifdef CDC_HS_TIMEOUT_EN
               cnt_d   = '0;
               abort_d = 1'b0;
`endif
            end
         end
         REQ: begin
            // A synced ack always wins over a coincident timeout.
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = DRAIN;
            end
`ifdef CDC_HS_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               abort_d = 1'b1;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DRAIN: begin
            if (!ack_s) begin
               state_d = IDLE;
`ifdef CDC_HS_TIMEOUT_EN
               done_d  = !abort_q;
               abort_d = 1'b0;
`else
               done_d  = 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign in_ready = (state_q == IDLE);
   assign busy_o   = (state_q != IDLE);
   assign req_o    = req_q;
   assign data_o   = data_q;
   assign done_o   = done_q;

`ifdef CDC_HS_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx with a behavioural destination responder.
// Covers table transfers, back-to-back, busy ignore, reset, timeout, jitter.
module tb_cdc_hs_tx;

   localparam int S  = 2;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       req_o;
   logic [7:0] data_o;
   logic       ack_i = 1'b0;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   cdc_hs_tx #(
      .DATA_W      (8),
      .SYNC_STAGES (S),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .req_o    (req_o),
      .data_o   (data_o),
      .ack_i    (ack_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .err_o    (err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];

   // Responder controls
   int rd1 = 3;
   int rd2 = 3;
   bit noack = 1'b0;
   bit jit = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Destination: latch word, raise ack d1 cycles after seeing req,
   // drop it d2 cycles after seeing req fall.
   int  d1, d2;
   bit  live;
   initial begin
      forever begin
         step();
         if (req_o && !noack) begin
            d1 = jit ? int'($urandom_range(0, 3)) : rd1;
            d2 = jit ? int'($urandom_range(0, 3)) : rd2;
            live = 1'b1;
            for (int i = 0; i < d1; i++) begin
               step();
               if (!req_o) begin
                  live = 1'b0;
                  break;
               end
            end
            if (live) begin
               if (jit) #($urandom_range(0, 7));
               rx_q.push_back(data_o);
               ack_i = 1'b1;
               while (req_o) step();
               for (int i = 0; i < d2; i++) step();
               if (jit) #($urandom_range(0, 7));
               ack_i = 1'b0;
            end
         end
      end
   end

   // Protocol monitors
   logic       req_prev = 1'b0;
   logic [7:0] data_prev = '0;
   always @(negedge clk) begin
      if (done_o === 1'b1) done_cnt++;
      if (!rst && req_o === 1'b1 && req_prev) begin
         checks++;
         if (data_o !== data_prev) begin
            errors++;
            $display("FAIL data_stable: got %0h expected %0h at %0t",
                     data_o, data_prev, $time);
         end
      end
      req_prev  = (req_o === 1'b1);
      data_prev = data_o;
   end

   always @(posedge ack_i) begin
      checks++;
      if (req_o !== 1'b1) begin
         errors++;
         $display("FAIL ack_without_req: req_o %b expected 1 at %0t",
                  req_o, $time);
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      chk("wait_ready", in_ready, 1);
   endtask

   // One transfer; with timed=1 the cycle offsets from acceptance edge are checked.
   task automatic xfer(input logic [7:0] w, input int a, input int b,
                       input bit timed);
      int k, kreq;
      bit seen;
      rd1 = a;
      rd2 = b;
      wait_ready();
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
      exp_q.push_back(w);
      if (timed) begin
         chk("req_rise", req_o, 1);
         chk("data_cap", data_o, w);
         chk("busy_in_req", busy_o, 1);
      end
      kreq = 0;
      seen = 1'b0;
      for (k = 1; k <= 300; k++) begin
         step();
         if (req_o !== 1'b1 && kreq == 0) kreq = k;
         if (done_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", seen, 1);
      if (timed) begin
         chk("req_fall_cyc", kreq, a + S + 1);
         chk("done_cyc", k, a + b + 2 * S + 2);
         chk("ready_with_done", in_ready, 1);
         step();
         chk("done_one_cycle", done_o, 0);
      end
   endtask

   typedef struct {
      logic [7:0] w;
      int         a;
      int         b;
   } vec_t;

   vec_t       tbl[5];
   logic [7:0] bb[3];
   int         base, wi, kk;
   bit         rdy;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time %0t expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'hA5, 3, 3};
      tbl[1] = '{8'h5A, 0, 0};
      tbl[2] = '{8'hC3, 1, 4};
      tbl[3] = '{8'h00, 2, 0};
      tbl[4] = '{8'hFF, 0, 5};
      bb[0] = 8'h01;
      bb[1] = 8'h02;
      bb[2] = 8'h03;

      // Reset state
      repeat (4) step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_req", req_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      rst = 1'b0;
      step();

      // Table transfers with exact latency
      foreach (tbl[i]) xfer(tbl[i].w, tbl[i].a, tbl[i].b, 1'b1);

      // Back-to-back with in_valid held
      rd1 = 1;
      rd2 = 1;
      wait_ready();
      base = done_cnt;
      wi = 0;
      in_valid = 1'b1;
      in_data  = bb[0];
      for (int c = 0; c < 400 && wi < 3; c++) begin
         rdy = (in_ready === 1'b1);
         step();
         if (rdy) begin
            chk("b2b_capture", data_o, bb[wi]);
            exp_q.push_back(bb[wi]);
            wi++;
            if (wi < 3) in_data = bb[wi];
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("b2b_accepted", wi, 3);
      kk = 0;
      while (done_cnt - base < 3 && kk < 300) begin
         step();
         kk++;
      end
      repeat (20) step();
      chk("b2b_done_cnt", done_cnt - base, 3);
      chk("b2b_idle_req", req_o, 0);

      // Busy ignore
      rd1 = 6;
      rd2 = 1;
      base = done_cnt;
      in_valid = 1'b1;
      in_data  = 8'h77;
      step();
      exp_q.push_back(8'h77);
      in_data = 8'hFF;
      repeat (4) step();
      chk("busy_hold_data", data_o, 8'h77);
      chk("busy_hold_req", req_o, 1);
      in_valid = 1'b0;
      kk = 0;
      while (done_cnt == base && kk < 300) begin
         step();
         kk++;
      end
      repeat (20) step();
      chk("busy_done_cnt", done_cnt - base, 1);
      chk("busy_no_extra", req_o, 0);
      chk("busy_data_kept", data_o, 8'h77);

      // Reset mid-handshake
      rd1 = 20;
      base = done_cnt;
      in_valid = 1'b1;
      in_data  = 8'h99;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("pre_rst_req", req_o, 1);
      rst = 1'b1;
      step();
      chk("midrst_req", req_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_ready", in_ready, 1);
      chk("midrst_data", data_o, 0);
      rst = 1'b0;
      repeat (3) step();
      chk("midrst_no_done", done_cnt - base, 0);
      xfer(8'h3C, 2, 2, 1'b1);

`ifdef CDC_HS_TIMEOUT_EN
      // Timeout with silent destination
      chk("pre_to_err", err_o, 0);
      noack = 1'b1;
      base = done_cnt;
      in_valid = 1'b1;
      in_data  = 8'h55;
      step();
      in_valid = 1'b0;
      kk = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (req_o !== 1'b1) begin
            kk = k;
            break;
         end
      end
      chk("to_req_fall", kk, TO);
      chk("to_err", err_o, 1);
      step();
      chk("to_idle", busy_o, 0);
      step();
      chk("to_no_done", done_cnt - base, 0);
      noack = 1'b0;
      xfer(8'h66, 1, 1, 1'b1);
      chk("err_sticky", err_o, 1);
`else
      chk("err_tied", err_o, 0);
`endif

      // Random words with sub-cycle ack jitter
      jit = 1'b1;
      base = done_cnt;
      for (int t = 0; t < 200; t++) begin
         xfer(8'($urandom), 0, 0, 1'b0);
      end
      repeat (5) step();
      jit = 1'b0;
      chk("jit_done_cnt", done_cnt - base, 200);

      // Scoreboard: every delivered word arrives in order
      chk("rx_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         chk("rx_word", rx_q[i], exp_q[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
